// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the LEGv8 instruction fetch stage.
package fetch_unit_pkg;

    // Datapath widths.
    localparam int INSTSIZE    = 32;
    localparam int REGDATASIZE = 64;

    // Fetch queue depth and the sequential PC step.
    localparam int                     FQ_DEPTH = 2;
    localparam logic [REGDATASIZE-1:0] PC_INC   = 64'd4;

    localparam int FQ_PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int FQ_OCC_W = $clog2(FQ_DEPTH + 1);

    typedef logic [REGDATASIZE-1:0] addr_t;
    typedef logic [INSTSIZE-1:0]    inst_t;
    typedef logic [FQ_PTR_W-1:0]    fq_ptr_t;
    typedef logic [FQ_OCC_W-1:0]    fq_occ_t;

    // One buffered instruction together with the address it was fetched from.
    typedef struct packed {
        inst_t inst;
        addr_t pc;
    } fq_entry_t;

    // Instructions are word aligned; redirect targets drop their low two bits.
    function automatic addr_t align_pc(input addr_t a);
        return {a[REGDATASIZE-1:2], 2'b00};
    endfunction

    // Sequential successor; wraps modulo 2^64.
    function automatic addr_t next_pc(input addr_t a);
        return a + PC_INC;
    endfunction

    // Circular pointer advance for the fetch queue.
    function automatic fq_ptr_t fq_bump(input fq_ptr_t p);
        return (p == fq_ptr_t'(FQ_DEPTH - 1)) ? '0 : p + fq_ptr_t'(1);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO holding fetched {inst, pc} pairs until decode accepts them.
// Enqueue and dequeue in the same cycle are both honoured. Flush empties the
// queue without touching storage; reset also zeroes storage so the head reads
// as zero out of reset.
module fetch_queue
    import fetch_unit_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      enq,
    input  fq_entry_t enq_data,
    input  logic      deq,
    input  logic      flush,
    output fq_occ_t   occ,
    output fq_entry_t head
);

    fq_entry_t [FQ_DEPTH-1:0] mem;
    fq_ptr_t                  rd_ptr;
    fq_ptr_t                  wr_ptr;
    logic                     full;
    logic                     do_enq;
    logic                     do_deq;

    assign full   = (occ == fq_occ_t'(FQ_DEPTH));
    assign do_deq = deq && (occ != '0);
    // A write into a full queue only lands if the head leaves in the same cycle.
    assign do_enq = enq && (!full || do_deq);
    assign head   = mem[rd_ptr];

    // Storage, pointers and occupancy; flush empties, reset also clears storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_enq) begin
                mem[wr_ptr] <= enq_data;
                wr_ptr      <= fq_bump(wr_ptr);
            end
            if (do_deq) begin
                rd_ptr <= fq_bump(rd_ptr);
            end
            occ <= occ + fq_occ_t'(do_enq) - fq_occ_t'(do_deq);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues word reads to a 1-cycle instruction
// memory, and hands {inst, pc} to decode over valid/ready. A redirect from
// execute reloads the PC and discards everything younger.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    // Must be word aligned.
    parameter logic [REGDATASIZE-1:0] RESET_PC = '0
)
(
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req,
    output logic [REGDATASIZE-1:0] imem_addr,
    input  logic                   imem_valid,
    input  logic [INSTSIZE-1:0]    imem_rdata,
    input  logic                   redirect_valid,
    input  logic [REGDATASIZE-1:0] redirect_pc,
    output logic                   if_valid,
    output logic [INSTSIZE-1:0]    if_inst,
    output logic [REGDATASIZE-1:0] if_pc,
    input  logic                   id_ready
);

    addr_t     pc;
    logic      inflight;
    addr_t     inflight_pc;

    fq_occ_t   occ;
    fq_entry_t head;
    fq_entry_t enq_data;
    logic      enq;
    logic      deq;

    // Slots already spoken for once this cycle's dequeue is accounted for.
    // A request may only go out if its response is guaranteed a queue slot.
    logic [FQ_OCC_W:0] committed;

    assign deq       = if_valid && id_ready;
    assign committed = {1'b0, occ} + (FQ_OCC_W+1)'(inflight) - (FQ_OCC_W+1)'(deq);

    assign imem_addr = pc;
    assign imem_req  = !rst && !redirect_valid
                       && (committed < (FQ_OCC_W+1)'(FQ_DEPTH));

    // Decode is held off while a redirect is flushing the queue.
    assign if_valid  = !rst && !redirect_valid && (occ != '0);
    assign if_inst   = head.inst;
    assign if_pc     = head.pc;

    // Responses with nothing outstanding, or arriving under a redirect, are dropped.
    assign enq           = imem_valid && inflight && !redirect_valid;
    assign enq_data.inst = imem_rdata;
    assign enq_data.pc   = inflight_pc;

    fetch_queue u_queue (
        .clk      (clk),
        .rst      (rst),
        .enq      (enq),
        .enq_data (enq_data),
        .deq      (deq),
        .flush    (redirect_valid),
        .occ      (occ),
        .head     (head)
    );

    // PC and outstanding-request tracking; redirect overrides sequential issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_valid) begin
            pc       <= align_pc(redirect_pc);
            inflight <= 1'b0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                pc          <= next_pc(pc);
                inflight_pc <= pc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed reset/stream/stall/redirect/wrap/reset
// scenarios followed by random traffic, checked by a scoreboard of expected
// instruction PCs plus a cycle-level model of issue credit and queue fill.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [63:0] RST_PC = 64'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [63:0] if_pc;
    logic        id_ready = 1'b0;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_valid     (imem_valid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_inst        (if_inst),
        .if_pc          (if_pc),
        .id_ready       (id_ready)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] gen_pc = RST_PC;
    logic        pend_req = 1'b0;
    logic [63:0] pend_addr = '0;
    logic        force_stray = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus: inputs change on the falling edge; memory answers
    // the request accepted at the previous rising edge with inst = addr[31:0].
    task automatic drive(input logic r, input logic rv, input logic [63:0] rpc, input logic rdy);
        @(negedge clk);
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        id_ready       = rdy;
        if (pend_req) begin
            imem_valid = 1'b1;
            imem_rdata = pend_addr[31:0];
        end else begin
            imem_valid = force_stray || ($urandom_range(7) == 0);
            imem_rdata = $urandom;
        end
        force_stray = 1'b0;
        // Expected delivery stream restarts at the reset PC or the aligned target.
        if (r) begin
            sb.delete();
            gen_pc = RST_PC;
        end else if (rv) begin
            sb.delete();
            gen_pc = {rpc[63:2], 2'b00};
        end
        while (sb.size() < 4) begin
            sb.push_back('{gen_pc, gen_pc[31:0]});
            gen_pc = gen_pc + 64'd4;
        end
        #1;
        pend_req  = imem_req;
        pend_addr = imem_addr;
    endtask

    // Monitor model state.
    int          occ_m = 0;
    logic        infl_m = 1'b0;
    logic [63:0] addr_m = RST_PC;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_pc = '0;
    logic [31:0] prev_inst = '0;
    logic        ev, dq, er, en;
    exp_t        e;

    // Monitor: per-cycle credit/valid model and in-order delivery scoreboard.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            occ_m      = 0;
            infl_m     = 1'b0;
            addr_m     = RST_PC;
            prev_stall = 1'b0;
        end else begin
            ev = (occ_m != 0) && !redirect_valid;
            dq = ev && id_ready;
            er = !redirect_valid && ((occ_m + int'(infl_m) - int'(dq)) < 2);
            check("imem_req", 64'(imem_req), 64'(er));
            check("imem_addr", imem_addr, addr_m);
            check("if_valid", 64'(if_valid), 64'(ev));
            if (prev_stall && !redirect_valid) begin
                check("hold_pc", if_pc, prev_pc);
                check("hold_inst", 64'(if_inst), 64'(prev_inst));
            end
            if (dq) begin
                check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("deliver_pc", if_pc, e.pc);
                    check("deliver_inst", 64'(if_inst), 64'(e.inst));
                end
            end
            en = imem_valid && infl_m && !redirect_valid;
            if (en) check("fq_overrun", 64'(occ_m == 2 && !dq), 64'd0);
            if (redirect_valid) begin
                occ_m      = 0;
                infl_m     = 1'b0;
                addr_m     = {redirect_pc[63:2], 2'b00};
                prev_stall = 1'b0;
            end else begin
                occ_m      = occ_m + int'(en) - int'(dq);
                infl_m     = er;
                if (er) addr_m = addr_m + 64'd4;
                prev_stall = ev && !id_ready;
                prev_pc    = if_pc;
                prev_inst  = if_inst;
            end
        end
    end

    logic [63:0] hold_pc;

    initial begin
        // Reset and reset values.
        drive(1, 0, 0, 1);
        drive(1, 0, 0, 1);
        check("rst_req", 64'(imem_req), 64'd0);
        check("rst_addr", imem_addr, RST_PC);
        check("rst_ifv", 64'(if_valid), 64'd0);
        check("rst_inst", 64'(if_inst), 64'd0);
        check("rst_pc", if_pc, 64'd0);

        // Release: req at cycle 0, first instruction at cycle 2.
        drive(0, 0, 0, 1);
        check("c0_req", 64'(imem_req), 64'd1);
        check("c0_addr", imem_addr, RST_PC);
        drive(0, 0, 0, 1);
        check("c1_ifv", 64'(if_valid), 64'd0);
        drive(0, 0, 0, 1);
        check("c2_ifv", 64'(if_valid), 64'd1);
        check("c2_pc", if_pc, RST_PC);
        check("c2_inst", 64'(if_inst), 64'd0);
        for (int i = 0; i < 7; i++) begin
            drive(0, 0, 0, 1);
            check("stream_ifv", 64'(if_valid), 64'd1);
            check("stream_pc", if_pc, 64'(4 * (i + 1)));
        end

        // Backpressure for 5 cycles: issue stops, head holds.
        drive(0, 0, 0, 0);
        hold_pc = if_pc;
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0);
            check("bp_req", 64'(imem_req), 64'd0);
            check("bp_pc", if_pc, hold_pc);
        end
        drive(0, 0, 0, 1);
        check("bp_resume_req", 64'(imem_req), 64'd1);
        check("bp_resume_pc", if_pc, hold_pc);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 1);

        // Redirect to an unaligned target with the queue filled.
        drive(0, 0, 0, 0);
        drive(0, 1, 64'h103, 1);
        check("rd_ifv", 64'(if_valid), 64'd0);
        check("rd_req", 64'(imem_req), 64'd0);
        drive(0, 0, 0, 1);
        check("rd1_req", 64'(imem_req), 64'd1);
        check("rd1_addr", imem_addr, 64'h100);
        drive(0, 0, 0, 1);
        check("rd2_ifv", 64'(if_valid), 64'd0);
        drive(0, 0, 0, 1);
        check("rd3_ifv", 64'(if_valid), 64'd1);
        check("rd3_pc", if_pc, 64'h100);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 1);

        // Wrap past the top of the address space, redirected mid-stream.
        drive(0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 1);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 1);
        check("wrap0_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        drive(0, 0, 0, 1);
        check("wrap1_pc", if_pc, 64'h0);
        drive(0, 0, 0, 1);
        check("wrap2_pc", if_pc, 64'h4);

        // One-cycle reset mid-stream with a response landing during reset
        // and a stray response right after release.
        drive(0, 0, 0, 1);
        drive(1, 0, 0, 1);
        force_stray = 1'b1;
        drive(0, 0, 0, 1);
        check("mr_ifv", 64'(if_valid), 64'd0);
        check("mr_pc", if_pc, 64'd0);
        check("mr_inst", 64'(if_inst), 64'd0);
        check("mr_addr", imem_addr, RST_PC);
        check("mr_req", 64'(imem_req), 64'd1);
        drive(0, 0, 0, 1);
        check("mr1_ifv", 64'(if_valid), 64'd0);
        drive(0, 0, 0, 1);
        check("mr2_ifv", 64'(if_valid), 64'd1);
        check("mr2_pc", if_pc, RST_PC);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            logic r, rv, rdy;
            logic [63:0] rpc;
            r   = ($urandom_range(99) == 0);
            rv  = !r && ($urandom_range(19) == 0);
            rpc = {$urandom, $urandom};
            rdy = ($urandom_range(9) < 7);
            drive(r, rv, rpc, rdy);
        end
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 1);
        @(negedge clk);
        #3;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
